dmem_arbiter: RTL

- Shares the single data memory between the core load/store path and a host burst port used for test preload and result readback.
- The core always has priority. Host bursts run in the free cycles left by the core.
- Sits between the core datapath (core-side address and write data), the data memory, and the bench/host loader.
- Memory read is combinational (same-cycle data). Memory write commits on the clk edge.

---
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: core load/store has priority, host bursts fill the free slots.
// Optional DMEM_ARB_STARVE_LIMIT_EN forces a host slot after MAX_WAIT blocked BURST cycles.
//
// state | meaning
// IDLE  | waiting for host_req; core owns every slot it asks for
// BURST | host words moved in cycles the core leaves free
// DONE  | one-cycle host_done pulse, then back to IDLE
module dmem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_mem_en,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_base,
    input  logic [AW-1:0] host_len,
    output logic          host_gnt,
    input  logic [DW-1:0] host_wdata,
    output logic          host_wready,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic          host_done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] len_q, len_d;
    logic          we_q, we_d;
    logic          host_slot;

`ifdef DMEM_ARB_STARVE_LIMIT_EN
    localparam int WW = $clog2(MAX_WAIT + 1);
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          force_host;
`else
    logic unused_cfg;
    assign unused_cfg = (MAX_WAIT > 0);
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        len_d       = len_q;
        we_d        = we_q;
        host_slot   = 1'b0;
        mem_addr    = core_addr;
        mem_we      = core_mem_en & core_we;
        mem_wdata   = core_wdata;
        core_rdata  = mem_rdata;
        core_stall  = 1'b0;
        host_gnt    = (state_q == BURST);
        host_wready = 1'b0;
        host_rvalid = 1'b0;
        host_rdata  = '0;
        host_done   = 1'b0;
`ifdef DMEM_ARB_STARVE_LIMIT_EN
        force_host  = (wait_cnt_q == WW'(MAX_WAIT));
        wait_cnt_d  = '0;
`endif

        case (state_q)
            IDLE: begin
                if (host_req) begin
                    base_d  = host_base;
                    len_d   = host_len;
                    we_d    = host_we;
                    cnt_d   = '0;
                    state_d = (host_len != '0) ? BURST : DONE;
                end
            end
            BURST: begin
`ifdef DMEM_ARB_STARVE_LIMIT_EN
                host_slot  = !core_mem_en || force_host;
                core_stall = core_mem_en && force_host;
                if (!host_slot) begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
`else
                host_slot  = !core_mem_en;
`endif
                if (host_slot) begin
                    mem_addr    = base_q + cnt_q;
                    mem_we      = we_q;
                    mem_wdata   = host_wdata;
                    host_wready = we_q;
                    host_rvalid = !we_q;
                    host_rdata  = we_q ? '0 : mem_rdata;
                    cnt_d       = cnt_q + AW'(1);
                    if (cnt_q == len_q - AW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                host_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset must block the write that would otherwise commit on the reset edge.
        if (reset) begin
            mem_we      = 1'b0;
            core_stall  = 1'b0;
            host_gnt    = 1'b0;
            host_wready = 1'b0;
            host_rvalid = 1'b0;
            host_rdata  = '0;
            host_done   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            len_q   <= len_d;
            we_q    <= we_d;
        end
    end

`ifdef DMEM_ARB_STARVE_LIMIT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

endmodule
